// File: rtl/fft_frame_ctrl_if.sv
// Stream bundle between the frame controller and the FFT core.
// The s_axis side feeds samples into the core, the m_axis side returns its spectrum.
interface fft_frame_ctrl_if;
   logic [31:0] s_axis_data_tdata;
   logic        s_axis_data_tvalid;
   logic        s_axis_data_tlast;
   logic        s_axis_data_tready;
   logic [47:0] m_axis_data_tdata;
   logic        m_axis_data_tvalid;
   logic        m_axis_data_tlast;
   logic        m_axis_data_tready;

   modport master (
      output s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
      input  s_axis_data_tready,
      input  m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
      output m_axis_data_tready
   );

   modport slave (
      input  s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
      output s_axis_data_tready,
      output m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast,
      input  m_axis_data_tready
   );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame controller: captures N ADC samples, streams them into an FFT core, then
// searches bins 1..N/2-1 of the returned spectrum for the largest magnitude.
module fft_frame_ctrl #(
   parameter int N     = 128,
   parameter int ADC_W = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADC_W-1:0]     adc_data,
   input  logic                 adc_valid,
   fft_frame_ctrl_if.master     axis,
   input  logic                 event_tlast_unexpected,
   input  logic                 event_tlast_missing,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [$clog2(N)-1:0] peak_bin,
   output logic [47:0]          peak_mag
);
   localparam int LG = $clog2(N);
   localparam logic [LG-1:0] LAST_IDX = LG'(N - 1);
   localparam logic [LG-1:0] HALF     = LG'(N / 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_STREAM,
      S_COLLECT,
      S_REPORT
   } state_t;

   state_t          r_state;
   logic [ADC_W-1:0] r_buf [N];
   logic [LG-1:0]   r_idx;
   logic [LG-1:0]   r_bin;
   logic            r_last_seen;
   logic            r_busy;
   logic            r_done;
   logic            r_error;
   logic [LG-1:0]   r_peak_bin;
   logic [47:0]     r_peak_mag;
   logic [31:0]     r_s_tdata;
   logic            r_s_tvalid;
   logic            r_s_tlast;
   logic            r_m_tready;
   logic            r_p1_valid;
   logic            r_p1_last;
   logic [LG-1:0]   r_p1_bin;
   logic [47:0]     r_p1_re2;
   logic [47:0]     r_p1_im2;
   logic [47:0]     r_pk_mag;
   logic [LG-1:0]   r_pk_bin;

   logic signed [23:0] w_m_re;
   logic signed [23:0] w_m_im;
   logic signed [47:0] w_re2;
   logic signed [47:0] w_im2;
   logic [47:0]        w_mag;
   logic [LG-1:0]      w_nxt_idx;
   logic               w_s_fire;
   logic               w_m_fire;
   logic               w_bin_last;
   logic               w_tlast_err;
   logic               w_abort;
   logic               w_pk_upd;

   function automatic logic [31:0] pack_sample(input logic [ADC_W-1:0] s);
      return {16'($signed(s)), 16'h0000};
   endfunction

   assign w_m_re      = axis.m_axis_data_tdata[47:24];
   assign w_m_im      = axis.m_axis_data_tdata[23:0];
   assign w_re2       = 48'(w_m_re) * 48'(w_m_re);
   assign w_im2       = 48'(w_m_im) * 48'(w_m_im);
   assign w_mag       = r_p1_re2 + r_p1_im2;
   assign w_nxt_idx   = r_idx + 1'b1;
   assign w_s_fire    = r_s_tvalid && axis.s_axis_data_tready;
   assign w_m_fire    = (r_state == S_COLLECT) && r_m_tready && axis.m_axis_data_tvalid && !r_last_seen;
   assign w_bin_last  = (r_bin == LAST_IDX);
   assign w_tlast_err = w_m_fire && (axis.m_axis_data_tlast != w_bin_last);
   assign w_abort     = ((r_state != S_IDLE) && (event_tlast_unexpected || event_tlast_missing)) || w_tlast_err;
   // Strictly-greater compare keeps the lowest bin on ties.
   assign w_pk_upd    = r_p1_valid && (r_p1_bin != '0) && (r_p1_bin < HALF) && (w_mag > r_pk_mag);

   assign axis.s_axis_data_tdata  = r_s_tdata;
   assign axis.s_axis_data_tvalid = r_s_tvalid;
   assign axis.s_axis_data_tlast  = r_s_tlast;
   assign axis.m_axis_data_tready = r_m_tready;
   assign busy     = r_busy;
   assign done     = r_done;
   assign error    = r_error;
   assign peak_bin = r_peak_bin;
   assign peak_mag = r_peak_mag;

   always_ff @(posedge clk) begin
      if (r_state == S_CAPTURE && adc_valid) r_buf[r_idx] <= adc_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_bin       <= '0;
         r_last_seen <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_peak_bin  <= '0;
         r_peak_mag  <= '0;
         r_s_tdata   <= '0;
         r_s_tvalid  <= 1'b0;
         r_s_tlast   <= 1'b0;
         r_m_tready  <= 1'b0;
         r_p1_valid  <= 1'b0;
         r_p1_last   <= 1'b0;
         r_p1_bin    <= '0;
         r_p1_re2    <= '0;
         r_p1_im2    <= '0;
         r_pk_mag    <= '0;
         r_pk_bin    <= '0;
      end else begin
         r_done     <= 1'b0;
         r_p1_valid <= w_m_fire;
         r_p1_last  <= w_bin_last;
         r_p1_bin   <= r_bin;
         r_p1_re2   <= w_re2;
         r_p1_im2   <= w_im2;

         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_CAPTURE;
                  r_error <= 1'b0;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_CAPTURE: begin
               if (adc_valid) begin
                  r_idx <= w_nxt_idx;
                  if (r_idx == LAST_IDX) begin
                     r_state    <= S_STREAM;
                     r_s_tvalid <= 1'b1;
                     r_s_tlast  <= 1'b0;
                     r_s_tdata  <= pack_sample(r_buf[0]);
                  end
               end
            end
            S_STREAM: begin
               if (w_s_fire) begin
                  if (r_s_tlast) begin
                     r_state     <= S_COLLECT;
                     r_s_tvalid  <= 1'b0;
                     r_s_tlast   <= 1'b0;
                     r_s_tdata   <= '0;
                     r_idx       <= '0;
                     r_m_tready  <= 1'b1;
                     r_bin       <= '0;
                     r_last_seen <= 1'b0;
                     r_pk_mag    <= '0;
                     r_pk_bin    <= '0;
                  end else begin
                     r_idx     <= w_nxt_idx;
                     r_s_tdata <= pack_sample(r_buf[w_nxt_idx]);
                     r_s_tlast <= (w_nxt_idx == LAST_IDX);
                  end
               end
            end
            S_COLLECT: begin
               if (w_pk_upd) begin
                  r_pk_mag <= w_mag;
                  r_pk_bin <= r_p1_bin;
               end
               if (w_m_fire && !w_tlast_err) begin
                  r_bin <= r_bin + 1'b1;
                  if (w_bin_last) r_last_seen <= 1'b1;
               end
               // Last bin is outside the search range, so r_pk is final once it reaches stage 1.
               if (r_p1_valid && r_p1_last) begin
                  r_state    <= S_REPORT;
                  r_m_tready <= 1'b0;
                  r_done     <= 1'b1;
                  r_peak_bin <= r_pk_bin;
                  r_peak_mag <= r_pk_mag;
               end
            end
            S_REPORT: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_error    <= 1'b1;
            r_done     <= 1'b0;
            r_s_tvalid <= 1'b0;
            r_s_tlast  <= 1'b0;
            r_s_tdata  <= '0;
            r_m_tready <= 1'b0;
            r_p1_valid <= 1'b0;
            r_idx      <= '0;
         end
      end
   end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with a behavioural DFT core model and
// a reference peak search computed directly from the spectrum values.
module tb_fft_frame_ctrl;
   localparam int N     = 128;
   localparam int ADC_W = 14;
   localparam real PI   = 3.14159265358979;

   logic clk;
   logic rst, start, adc_valid, ev_unexp, ev_miss;
   logic [ADC_W-1:0] adc_data;
   logic busy, done, error;
   logic [6:0]  peak_bin;
   logic [47:0] peak_mag;

   fft_frame_ctrl_if axis_if();

   fft_frame_ctrl #(.N(N), .ADC_W(ADC_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .adc_data(adc_data), .adc_valid(adc_valid),
      .axis(axis_if),
      .event_tlast_unexpected(ev_unexp), .event_tlast_missing(ev_miss),
      .busy(busy), .done(done), .error(error),
      .peak_bin(peak_bin), .peak_mag(peak_mag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] data; logic last; } samp_t;
   typedef struct { int pb; longint pm; } rep_t;

   int     tests = 0;
   int     fails = 0;
   int     done_cnt = 0;
   samp_t  q_exp[$];
   rep_t   q_rep[$];
   int     smp[N];
   bit     plan_custom;
   int     plan_re[N];
   int     plan_im[N];
   int     plan_lastbin;
   bit     stall_mode;
   int     rx[$];
   logic [48:0] q_out[$];
   bit     m_hold;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int rnd(input real x);
      if (x >= 0.0) return $rtoi(x + 0.5);
      return -$rtoi(-x + 0.5);
   endfunction

   function automatic void dft(input int xs[N], output int ore[N], output int oim[N]);
      for (int k = 0; k < N; k++) begin
         real sr, si, a;
         sr = 0.0;
         si = 0.0;
         for (int n = 0; n < N; n++) begin
            a  = 2.0 * PI * real'((k * n) % N) / real'(N);
            sr = sr + real'(xs[n]) * $cos(a);
            si = si - real'(xs[n]) * $sin(a);
         end
         ore[k] = rnd(sr);
         oim[k] = rnd(si);
      end
   endfunction

   function automatic rep_t ref_peak(input int re[N], input int im[N]);
      rep_t r;
      longint m;
      r.pb = 0;
      r.pm = 0;
      for (int k = 1; k < N / 2; k++) begin
         m = longint'(re[k]) * longint'(re[k]) + longint'(im[k]) * longint'(im[k]);
         if (m > r.pm) begin
            r.pb = k;
            r.pm = m;
         end
      end
      return r;
   endfunction

   // FFT core model: collects a frame, then returns its spectrum (or a planned table).
   initial begin
      axis_if.s_axis_data_tready = 1'b0;
      axis_if.m_axis_data_tvalid = 1'b0;
      axis_if.m_axis_data_tdata  = '0;
      axis_if.m_axis_data_tlast  = 1'b0;
      m_hold = 1'b0;
      forever begin
         @(negedge clk);
         axis_if.s_axis_data_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         if (q_out.size() > 0 && (m_hold || !stall_mode || $urandom_range(0, 3) != 0)) begin
            axis_if.m_axis_data_tvalid = 1'b1;
            {axis_if.m_axis_data_tdata, axis_if.m_axis_data_tlast} = q_out[0];
         end else begin
            axis_if.m_axis_data_tvalid = 1'b0;
         end
         #1;
         if (!rst && axis_if.s_axis_data_tvalid && axis_if.s_axis_data_tready) begin
            rx.push_back(int'($signed(axis_if.s_axis_data_tdata[31:16])));
            if (rx.size() == N) begin
               int xs[N], ore[N], oim[N];
               logic [23:0] r24, i24;
               for (int i = 0; i < N; i++) xs[i] = rx[i];
               rx.delete();
               if (plan_custom) begin
                  ore = plan_re;
                  oim = plan_im;
               end else begin
                  dft(xs, ore, oim);
               end
               for (int k = 0; k < N; k++) begin
                  r24 = ore[k][23:0];
                  i24 = oim[k][23:0];
                  q_out.push_back({r24, i24, (k == plan_lastbin)});
               end
            end
         end
         m_hold = 1'b0;
         if (!rst && axis_if.m_axis_data_tvalid) begin
            if (axis_if.m_axis_data_tready) void'(q_out.pop_front());
            else m_hold = 1'b1;
         end
      end
   end

   // Monitor: scoreboard for streamed samples, stall stability and reports.
   initial begin
      bit          prev_stall;
      logic [31:0] prev_data;
      logic        prev_last;
      samp_t       e;
      rep_t        r;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_tvalid", axis_if.s_axis_data_tvalid, 1);
               check("stall_tdata", axis_if.s_axis_data_tdata, prev_data);
               check("stall_tlast", axis_if.s_axis_data_tlast, prev_last);
            end
            if (axis_if.s_axis_data_tvalid && axis_if.s_axis_data_tready) begin
               if (q_exp.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL extra_sample: got tdata %h with no expected sample", axis_if.s_axis_data_tdata);
               end else begin
                  e = q_exp.pop_front();
                  check("s_tdata", axis_if.s_axis_data_tdata, e.data);
                  check("s_tlast", axis_if.s_axis_data_tlast, e.last);
               end
            end
            prev_stall = axis_if.s_axis_data_tvalid && !axis_if.s_axis_data_tready;
            prev_data  = axis_if.s_axis_data_tdata;
            prev_last  = axis_if.s_axis_data_tlast;
            if (done) begin
               done_cnt++;
               if (q_rep.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL extra_done: got done with peak_bin %0d, no report expected", peak_bin);
               end else begin
                  r = q_rep.pop_front();
                  check("peak_bin", peak_bin, r.pb);
                  check("peak_mag", peak_mag, r.pm);
               end
            end
         end
      end
   end

   task automatic model_reset();
      @(posedge clk);
      #2;
      rx.delete();
      q_out.delete();
      q_exp.delete();
      m_hold = 1'b0;
   endtask

   task automatic launch();
      int  v;
      bit  vld;
      for (int i = 0; i < N; i++) begin
         v = smp[i];
         q_exp.push_back('{data: {v[15:0], 16'h0000}, last: (i == N - 1)});
      end
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      #2;
      check("busy_after_start", busy, 1);
      check("error_cleared", error, 0);
      for (int i = 0; i < N; i++) begin
         do begin
            @(negedge clk);
            vld       = ($urandom_range(0, 3) != 0);
            adc_valid = vld;
            v         = smp[i];
            adc_data  = v[ADC_W-1:0];
         end while (!vld);
      end
      @(negedge clk) adc_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         #2;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: busy still 1 after 6000 cycles, required 0", tag);
      end
   endtask

   task automatic run_frame(input string tag, input bit expect_ok);
      int   d0, ore[N], oim[N];
      rep_t r;
      d0 = done_cnt;
      if (expect_ok) begin
         if (plan_custom) r = ref_peak(plan_re, plan_im);
         else begin
            dft(smp, ore, oim);
            r = ref_peak(ore, oim);
         end
         q_rep.push_back(r);
      end
      launch();
      wait_idle(tag);
      check({tag, "_done_pulses"}, done_cnt - d0, expect_ok ? 1 : 0);
      check({tag, "_error"}, error, expect_ok ? 0 : 1);
      if (expect_ok) check({tag, "_samples_left"}, q_exp.size(), 0);
   endtask

   task automatic rand_samples();
      for (int i = 0; i < N; i++) smp[i] = int'($urandom_range(0, 16383)) - 8192;
   endtask

   initial begin
      int pb_hold;
      rst = 1'b1; start = 1'b0; adc_valid = 1'b0; adc_data = '0;
      ev_unexp = 1'b0; ev_miss = 1'b0;
      stall_mode = 1'b0; plan_custom = 1'b0; plan_lastbin = N - 1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_peak_bin", peak_bin, 0);
      check("rst_peak_mag", peak_mag, 0);
      check("rst_s_tvalid", axis_if.s_axis_data_tvalid, 0);
      check("rst_s_tlast", axis_if.s_axis_data_tlast, 0);
      check("rst_s_tdata", axis_if.s_axis_data_tdata, 0);
      check("rst_m_tready", axis_if.m_axis_data_tready, 0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < N; i++) smp[i] = rnd(8000.0 * $sin(2.0 * PI * 10.0 * real'(i) / real'(N)));
      run_frame("sine", 1);
      check("sine_bin10", peak_bin, 10);

      stall_mode = 1'b1;
      rand_samples();
      run_frame("stall", 1);
      stall_mode = 1'b0;

      for (int i = 0; i < N; i++) smp[i] = -1;
      run_frame("minus1", 1);

      plan_custom = 1'b1;
      for (int k = 0; k < N; k++) begin
         plan_re[k] = 0;
         plan_im[k] = 0;
      end
      plan_re[0] = 2000000; plan_re[100] = 3000000;
      plan_re[5] = 1000;    plan_im[9]   = 1000;
      rand_samples();
      run_frame("tie", 1);
      check("tie_bin5", peak_bin, 5);

      for (int k = 0; k < N; k++) begin
         plan_re[k] = int'($urandom_range(0, 4000)) - 2000;
         plan_im[k] = int'($urandom_range(0, 4000)) - 2000;
      end
      plan_lastbin = 60;
      run_frame("tlast60", 0);
      model_reset();
      plan_lastbin = N - 1;
      plan_custom = 1'b0;
      rand_samples();
      run_frame("recover", 1);

      pb_hold = int'(peak_bin);
      rand_samples();
      launch();
      repeat (5) @(negedge clk);
      ev_miss = 1'b1;
      @(negedge clk) ev_miss = 1'b0;
      #2;
      check("evt_error", error, 1);
      check("evt_busy", busy, 0);
      check("evt_peak_hold", peak_bin, pb_hold);
      model_reset();

      rand_samples();
      launch();
      for (int c = 0; c < 3000 && rx.size() < 50; c++) @(negedge clk);
      if (rx.size() < 50) begin
         tests++;
         fails++;
         $display("FAIL rst_wait: got %0d samples streamed, required 50", rx.size());
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_tvalid", axis_if.s_axis_data_tvalid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_peak_bin", peak_bin, 0);
      check("midrst_peak_mag", peak_mag, 0);
      check("midrst_m_tready", axis_if.m_axis_data_tready, 0);
      @(negedge clk) rst = 1'b0;
      model_reset();
      rand_samples();
      run_frame("fresh", 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
